// File: rtl/imem_load_arbiter.sv
// Shares the single-port instruction memory between fetch reads and loader writes; BOOT holds fetch until ld_done.
// Grants are combinational, read data is registered one cycle after the grant; loader priority is capped by MAX_LD_BURST.
module imem_load_arbiter #(
  parameter int DEPTH        = 64,
  parameter int AW           = 6,
  parameter int MAX_LD_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fetch_req,
  input  logic [31:0]   fetch_addr,
  input  logic          fetch_flush,
  output logic          fetch_gnt,
  output logic          fetch_stall,
  output logic          fetch_valid,
  output logic [31:0]   fetch_instr,
  input  logic          ld_req,
  input  logic [31:0]   ld_addr,
  input  logic [31:0]   ld_data,
  input  logic          ld_done,
  output logic          ld_gnt,
  output logic          ld_err,
  output logic          boot_done,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam int BW = $clog2(MAX_LD_BURST + 1);

  typedef enum logic {BOOT, RUN} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic          fetch_valid_q, fetch_valid_d;
  logic [31:0]   fetch_instr_q, fetch_instr_d;
  logic          ld_err_q, ld_err_d;
  logic          ld_in_range;
  logic          burst_full;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{fetch_addr[31:AW+2], fetch_addr[1:0], ld_addr[1:0]};

  assign ld_in_range = (ld_addr[31:2] < 30'(DEPTH));
  assign burst_full  = (burst_cnt_q == BW'(MAX_LD_BURST));

  always_comb begin
    state_d       = state_q;
    burst_cnt_d   = burst_cnt_q;
    fetch_gnt     = 1'b0;
    ld_gnt        = 1'b0;
    mem_addr      = '0;
    mem_we        = 1'b0;
    mem_wdata     = '0;
    fetch_valid_d = 1'b0;
    fetch_instr_d = fetch_instr_q;
    ld_err_d      = 1'b0;

    case (state_q)
      BOOT: begin
        ld_gnt = ld_req;
        if (ld_done) state_d = RUN;
      end
      RUN: begin
        if (fetch_req && (!ld_req || burst_full)) fetch_gnt = 1'b1;
        else if (ld_req)                          ld_gnt    = 1'b1;
      end
      default: state_d = BOOT;
    endcase

    if (fetch_gnt) begin
      mem_addr = fetch_addr[AW+1:2];
    end else if (ld_gnt) begin
      mem_addr  = ld_addr[AW+1:2];
      mem_wdata = ld_data;
      mem_we    = ld_in_range;
    end

    // Counts loader wins only while a fetch is waiting; any fetch grant or idle fetch clears it.
    if (!fetch_req || fetch_gnt)            burst_cnt_d = '0;
    else if (ld_gnt && !burst_full)         burst_cnt_d = burst_cnt_q + 1'b1;

    if (fetch_gnt && !fetch_flush) begin
      fetch_valid_d = 1'b1;
      fetch_instr_d = mem_rdata;
    end
    ld_err_d = ld_gnt && !ld_in_range;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= BOOT;
      burst_cnt_q   <= '0;
      fetch_valid_q <= 1'b0;
      fetch_instr_q <= '0;
      ld_err_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      burst_cnt_q   <= burst_cnt_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_instr_q <= fetch_instr_d;
      ld_err_q      <= ld_err_d;
    end
  end

  assign fetch_stall = fetch_req & ~fetch_gnt;
  assign fetch_valid = fetch_valid_q;
  assign fetch_instr = fetch_instr_q;
  assign ld_err      = ld_err_q;
  assign boot_done   = (state_q == RUN);

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Directed bench for imem_load_arbiter with a behavioural single-port memory attached.
module tb_imem_load_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req, fetch_flush, ld_req, ld_done;
  logic [31:0] fetch_addr, ld_addr, ld_data;
  logic        fetch_gnt, fetch_stall, fetch_valid, ld_gnt, ld_err, boot_done, mem_we;
  logic [31:0] fetch_instr, mem_wdata, mem_rdata;
  logic [5:0]  mem_addr;
  logic [31:0] mem [0:63];

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  imem_load_arbiter #(.DEPTH(64), .AW(6), .MAX_LD_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_flush(fetch_flush),
    .fetch_gnt(fetch_gnt), .fetch_stall(fetch_stall), .fetch_valid(fetch_valid),
    .fetch_instr(fetch_instr),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_done(ld_done),
    .ld_gnt(ld_gnt), .ld_err(ld_err), .boot_done(boot_done),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; fetch_req = 1'b1; fetch_addr = 32'h0; fetch_flush = 1'b0;
    ld_req = 1'b0; ld_addr = 32'h0; ld_data = 32'h0; ld_done = 1'b0;
    settle();
    chk_cnt++; if (fetch_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", fetch_valid); else pass_cnt++;
    chk_cnt++; if (fetch_instr !== 32'h0) $display("FAIL rst_instr got %h exp 0", fetch_instr); else pass_cnt++;
    chk_cnt++; if (ld_err !== 1'b0) $display("FAIL rst_ld_err got %b exp 0", ld_err); else pass_cnt++;
    step(); step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk_cnt++; if (fetch_gnt !== 1'b0) $display("FAIL boot_fetch_gnt[%0d] got %b exp 0", i, fetch_gnt); else pass_cnt++;
      chk_cnt++; if (fetch_stall !== 1'b1) $display("FAIL boot_stall[%0d] got %b exp 1", i, fetch_stall); else pass_cnt++;
      chk_cnt++; if (boot_done !== 1'b0) $display("FAIL boot_done_low[%0d] got %b exp 0", i, boot_done); else pass_cnt++;
      chk_cnt++; if (fetch_valid !== 1'b0) $display("FAIL boot_valid[%0d] got %b exp 0", i, fetch_valid); else pass_cnt++;
      step();
    end
    fetch_req = 1'b0;
    step();
  endtask

  task automatic test_boot_load();
    ld_req = 1'b1; ld_addr = 32'h0; ld_data = 32'h8020000A;
    settle();
    chk_cnt++; if (ld_gnt !== 1'b1) $display("FAIL load0_gnt got %b exp 1", ld_gnt); else pass_cnt++;
    chk_cnt++; if ({mem_we, mem_addr} !== {1'b1, 6'd0}) $display("FAIL load0_mem got we=%b addr=%0d exp we=1 addr=0", mem_we, mem_addr); else pass_cnt++;
    chk_cnt++; if (mem_wdata !== 32'h8020000A) $display("FAIL load0_wdata got %h exp 8020000a", mem_wdata); else pass_cnt++;
    step();
    ld_addr = 32'h4; ld_data = 32'h04200800; ld_done = 1'b1;
    settle();
    chk_cnt++; if ({mem_we, mem_addr} !== {1'b1, 6'd1}) $display("FAIL load1_mem got we=%b addr=%0d exp we=1 addr=1", mem_we, mem_addr); else pass_cnt++;
    chk_cnt++; if (boot_done !== 1'b0) $display("FAIL boot_done_early got %b exp 0", boot_done); else pass_cnt++;
    step();
    ld_req = 1'b0; ld_done = 1'b0;
    fetch_req = 1'b1; fetch_addr = 32'h4;
    settle();
    chk_cnt++; if (boot_done !== 1'b1) $display("FAIL boot_done got %b exp 1", boot_done); else pass_cnt++;
    chk_cnt++; if ({fetch_gnt, fetch_stall, mem_we, mem_addr} !== {3'b100, 6'd1}) $display("FAIL run_fetch got gnt=%b stall=%b we=%b addr=%0d exp 1 0 0 1", fetch_gnt, fetch_stall, mem_we, mem_addr); else pass_cnt++;
    step();
    fetch_req = 1'b0;
    settle();
    chk_cnt++; if ({fetch_valid, fetch_instr} !== {1'b1, 32'h04200800}) $display("FAIL fetch_word1 got v=%b %h exp v=1 04200800", fetch_valid, fetch_instr); else pass_cnt++;
    step();
    chk_cnt++; if ({fetch_valid, fetch_instr} !== {1'b0, 32'h04200800}) $display("FAIL fetch_hold got v=%b %h exp v=0 04200800", fetch_valid, fetch_instr); else pass_cnt++;
    chk_cnt++; if ({mem_we, mem_addr} !== {1'b0, 6'd0}) $display("FAIL idle_mem got we=%b addr=%0d exp 0 0", mem_we, mem_addr); else pass_cnt++;
  endtask

  task automatic test_burst_limit();
    logic exp_f;
    ld_req = 1'b1; ld_addr = 32'h8; fetch_req = 1'b1; fetch_addr = 32'h0;
    for (int i = 0; i < 10; i++) begin
      ld_data = 32'h100 + i;
      settle();
      exp_f = (i % 5 == 4);
      chk_cnt++; if ({fetch_gnt, ld_gnt, fetch_stall} !== {exp_f, ~exp_f, ~exp_f})
        $display("FAIL burst[%0d] got fgnt=%b lgnt=%b stall=%b exp %b %b %b", i, fetch_gnt, ld_gnt, fetch_stall, exp_f, ~exp_f, ~exp_f);
      else pass_cnt++;
      step();
    end
    ld_req = 1'b0; fetch_req = 1'b0;
    step();
  endtask

  task automatic test_out_of_range();
    ld_req = 1'b1; ld_addr = 32'h100; ld_data = 32'hDEADBEEF;
    settle();
    chk_cnt++; if ({ld_gnt, mem_we, ld_err} !== 3'b100) $display("FAIL oor_cycle got gnt=%b we=%b err=%b exp 1 0 0", ld_gnt, mem_we, ld_err); else pass_cnt++;
    step();
    ld_req = 1'b0;
    settle();
    chk_cnt++; if (ld_err !== 1'b1) $display("FAIL oor_err got %b exp 1", ld_err); else pass_cnt++;
    step();
    chk_cnt++; if (ld_err !== 1'b0) $display("FAIL oor_err_clear got %b exp 0", ld_err); else pass_cnt++;
    fetch_req = 1'b1; fetch_addr = 32'h0;
    step();
    fetch_req = 1'b0;
    settle();
    chk_cnt++; if ({fetch_valid, fetch_instr} !== {1'b1, 32'h8020000A}) $display("FAIL oor_word0 got v=%b %h exp v=1 8020000a", fetch_valid, fetch_instr); else pass_cnt++;
    step();
  endtask

  task automatic test_flush();
    fetch_req = 1'b1; fetch_addr = 32'h4; fetch_flush = 1'b1;
    settle();
    chk_cnt++; if (fetch_gnt !== 1'b1) $display("FAIL flush_gnt got %b exp 1", fetch_gnt); else pass_cnt++;
    step();
    fetch_flush = 1'b0;
    settle();
    chk_cnt++; if ({fetch_valid, fetch_instr} !== {1'b0, 32'h8020000A}) $display("FAIL flush_kill got v=%b %h exp v=0 8020000a", fetch_valid, fetch_instr); else pass_cnt++;
    step();
    fetch_req = 1'b0;
    settle();
    chk_cnt++; if ({fetch_valid, fetch_instr} !== {1'b1, 32'h04200800}) $display("FAIL flush_next got v=%b %h exp v=1 04200800", fetch_valid, fetch_instr); else pass_cnt++;
    step();
  endtask

  task automatic test_reset_mid();
    fetch_req = 1'b1; fetch_addr = 32'h0;
    step();
    chk_cnt++; if (fetch_valid !== 1'b1) $display("FAIL mid_pre_valid got %b exp 1", fetch_valid); else pass_cnt++;
    #2 rst = 1'b0;
    #1;
    chk_cnt++; if ({fetch_valid, fetch_instr, boot_done} !== {1'b0, 32'h0, 1'b0}) $display("FAIL mid_rst got v=%b %h bd=%b exp 0 0 0", fetch_valid, fetch_instr, boot_done); else pass_cnt++;
    step();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk_cnt++; if ({fetch_gnt, fetch_stall} !== 2'b01) $display("FAIL reboot_block[%0d] got gnt=%b stall=%b exp 0 1", i, fetch_gnt, fetch_stall); else pass_cnt++;
      step();
    end
    fetch_req = 1'b0; ld_done = 1'b1;
    step();
    ld_done = 1'b0; fetch_req = 1'b1; fetch_addr = 32'h4;
    settle();
    chk_cnt++; if (boot_done !== 1'b1) $display("FAIL reboot_done got %b exp 1", boot_done); else pass_cnt++;
    step();
    fetch_addr = 32'h0;
    settle();
    chk_cnt++; if ({fetch_valid, fetch_instr} !== {1'b1, 32'h04200800}) $display("FAIL reboot_word1 got v=%b %h exp v=1 04200800", fetch_valid, fetch_instr); else pass_cnt++;
    step();
    fetch_req = 1'b0;
    settle();
    chk_cnt++; if ({fetch_valid, fetch_instr} !== {1'b1, 32'h8020000A}) $display("FAIL reboot_word0 got v=%b %h exp v=1 8020000a", fetch_valid, fetch_instr); else pass_cnt++;
    step();
  endtask

  initial begin
    test_reset();
    test_boot_load();
    test_burst_limit();
    test_out_of_range();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
